// File: rtl/iomem_pkg.sv
// Shared definitions for the iomem initiator: state encoding, strobe codes
// and the board memory map.
package iomem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_GAP_R = 3'd2,
    ST_WR    = 3'd3,
    ST_GAP_W = 3'd4,
    ST_FIN   = 3'd5
  } state_e;

  localparam logic [3:0]  WSTRB_READ    = 4'h0;
  localparam logic [3:0]  WSTRB_WORD    = 4'hF;

  localparam logic [31:0] MAIN_MEM_BASE = 32'h4000_0000;
  localparam logic [31:0] MAIN_MEM_MASK = 32'h00FF_FFFF;
  localparam logic [31:0] TIMER_LO_ADDR = 32'h3000_0000;
  localparam logic [31:0] TIMER_HI_ADDR = 32'h3000_0004;

endpackage

// File: rtl/iomem_watchdog.sv
// Counts cycles a request has been waiting for ready; flags expiry in the
// last waiting cycle so the engine can drop valid on the following cycle.
module iomem_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk_wiz_o,
  input  logic rst_n,
  input  logic valid,
  input  logic ready,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;

  // Wait counter: restarts whenever no request is pending or one completes.
  always_ff @(posedge clk_wiz_o) begin
    if (!rst_n)                cnt_q <= '0;
    else if (!valid || ready)  cnt_q <= '0;
    else                       cnt_q <= cnt_q + CW'(1);
  end

  // Fires in the TIMEOUT_CYCLES-th consecutive cycle of valid without ready.
  assign expired = valid && !ready && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/iomem_copy_master.sv
// Word block-copy / block-fill initiator for the iomem handshake.
// Every output is a flop; bus fields are loaded on entry to RD/WR and held
// while valid is high.
module iomem_copy_master import iomem_pkg::*; #(
  parameter int LEN_W          = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk_wiz_o,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             mode_i,
  input  logic [31:0]      src_addr_i,
  input  logic [31:0]      dst_addr_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [31:0]      fill_data_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [LEN_W-1:0] words_done_o,
  output logic             iomem_valid_o,
  input  logic             iomem_ready_i,
  output logic [3:0]       iomem_wstrb_o,
  output logic [31:0]      iomem_addr_o,
  output logic [31:0]      iomem_wdata_o,
  input  logic [31:0]      iomem_rdata_i
);

  state_e           state_q, state_d;
  logic             mode_q;
  logic [31:0]      src_q, dst_q, fill_q, data_q;
  logic [LEN_W-1:0] len_q, cnt_inc;
  logic             hs, expired;
  logic [31:0]      src_entry, dst_entry, wdata_entry;

  assign hs      = iomem_valid_o && iomem_ready_i;
  assign cnt_inc = words_done_o + LEN_W'(1);

  // Bus fields for the transaction about to start: straight from the inputs
  // when leaving IDLE, otherwise from the running registers.
  assign src_entry   = (state_q == ST_IDLE) ? (src_addr_i & ~32'h3) : src_q;
  assign dst_entry   = (state_q == ST_IDLE) ? (dst_addr_i & ~32'h3) : dst_q;
  assign wdata_entry = (state_q == ST_IDLE) ? fill_data_i
                     : (mode_q ? fill_q : data_q);

  iomem_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .clk_wiz_o (clk_wiz_o),
    .rst_n     (rst_n),
    .valid     (iomem_valid_o),
    .ready     (iomem_ready_i),
    .expired   (expired)
  );

  // Next-state logic; timeout overrides the handshake in both bus states.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_i) state_d = (len_i == '0) ? ST_FIN
                                     : (mode_i ? ST_WR : ST_RD);
      ST_RD:    if (expired) state_d = ST_FIN;
                else if (hs) state_d = ST_GAP_R;
      ST_GAP_R: state_d = ST_WR;
      ST_WR:    if (expired) state_d = ST_FIN;
                else if (hs) state_d = (cnt_inc == len_q) ? ST_FIN : ST_GAP_W;
      ST_GAP_W: state_d = mode_q ? ST_WR : ST_RD;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State, registered outputs and datapath.
  always_ff @(posedge clk_wiz_o) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
      words_done_o  <= '0;
      iomem_valid_o <= 1'b0;
      iomem_wstrb_o <= WSTRB_READ;
      iomem_addr_o  <= '0;
      iomem_wdata_o <= '0;
      mode_q        <= 1'b0;
      src_q         <= '0;
      dst_q         <= '0;
      len_q         <= '0;
      fill_q        <= '0;
      data_q        <= '0;
    end else begin
      state_q       <= state_d;
      busy_o        <= (state_d != ST_IDLE);
      done_o        <= (state_q == ST_FIN);
      iomem_valid_o <= (state_d == ST_RD) || (state_d == ST_WR);

      if (state_q == ST_IDLE && start_i) begin
        mode_q       <= mode_i;
        src_q        <= src_addr_i & ~32'h3;
        dst_q        <= dst_addr_i & ~32'h3;
        len_q        <= len_i;
        fill_q       <= fill_data_i;
        err_o        <= 1'b0;
        words_done_o <= '0;
      end

      if (state_d == ST_RD && state_q != ST_RD) begin
        iomem_addr_o  <= src_entry;
        iomem_wstrb_o <= WSTRB_READ;
      end
      if (state_d == ST_WR && state_q != ST_WR) begin
        iomem_addr_o  <= dst_entry;
        iomem_wstrb_o <= WSTRB_WORD;
        iomem_wdata_o <= wdata_entry;
      end

      if (state_q == ST_RD && hs) begin
        data_q <= iomem_rdata_i;
        src_q  <= src_q + 32'd4;
      end
      if (state_q == ST_WR && hs) begin
        dst_q        <= dst_q + 32'd4;
        words_done_o <= cnt_inc;
      end

      if (expired) err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_iomem_copy_master.sv
// Directed bench for iomem_copy_master with a fixed-latency memory responder.
module tb_iomem_copy_master;

  logic        clk_wiz_o = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0, mode_i = 1'b0;
  logic [31:0] src_addr_i = '0, dst_addr_i = '0, fill_data_i = '0;
  logic [15:0] len_i = '0;
  logic        busy_o, done_o, err_o, iomem_valid_o;
  logic [15:0] words_done_o;
  logic        iomem_ready_i = 1'b0;
  logic [3:0]  iomem_wstrb_o;
  logic [31:0] iomem_addr_o, iomem_wdata_o;
  logic [31:0] iomem_rdata_i = '0;

  iomem_copy_master #(.LEN_W(16), .TIMEOUT_CYCLES(64)) dut (
    .clk_wiz_o(clk_wiz_o), .rst_n(rst_n), .start_i(start_i), .mode_i(mode_i),
    .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .len_i(len_i),
    .fill_data_i(fill_data_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .words_done_o(words_done_o), .iomem_valid_o(iomem_valid_o),
    .iomem_ready_i(iomem_ready_i), .iomem_wstrb_o(iomem_wstrb_o),
    .iomem_addr_o(iomem_addr_o), .iomem_wdata_o(iomem_wdata_o),
    .iomem_rdata_i(iomem_rdata_i)
  );

  always #5 clk_wiz_o = ~clk_wiz_o;

  typedef struct { logic [31:0] addr; logic [3:0] wstrb; logic [31:0] data; } txn_t;

  int          n_cmp = 0, n_bad = 0;
  int          cyc = 0, t0 = 0;
  int          lat = 16, wcnt = 0;
  bit          resp_en = 1'b1, prev_rdy = 1'b0;
  int          done_cnt = 0, done_cyc = -1, last_rdy = -1;
  int          vrun = 0, last_vrun = 0, vtotal = 0, gapv = 0;
  logic [31:0] mem [logic [31:0]];
  txn_t        log_q[$];

  always @(posedge clk_wiz_o) cyc <= cyc + 1;

  // Responder and monitor, mid-cycle: ready rises L cycles after valid does.
  always @(negedge clk_wiz_o) begin
    if (prev_rdy && iomem_valid_o) gapv++;
    if (iomem_valid_o) begin vrun++; vtotal++; end
    else if (vrun > 0) begin last_vrun = vrun; vrun = 0; end
    if (done_o) begin done_cnt++; done_cyc = cyc - t0; end
    iomem_ready_i = 1'b0;
    if (iomem_valid_o && resp_en) begin
      wcnt++;
      if (wcnt == lat + 1) begin
        iomem_ready_i = 1'b1;
        last_rdy = cyc - t0;
        if (iomem_wstrb_o == 4'hF) begin
          mem[iomem_addr_o] = iomem_wdata_o;
          log_q.push_back('{iomem_addr_o, iomem_wstrb_o, iomem_wdata_o});
        end else begin
          iomem_rdata_i = mem.exists(iomem_addr_o) ? mem[iomem_addr_o] : 32'h0;
          log_q.push_back('{iomem_addr_o, iomem_wstrb_o, iomem_rdata_i});
        end
      end
    end else wcnt = 0;
    prev_rdy = iomem_ready_i;
  end

  // Pulse start for one cycle (cycle 0); returns at the cycle-1 negedge.
  task automatic do_start(input bit m, input logic [31:0] s, input logic [31:0] d,
                          input logic [15:0] n, input logic [31:0] f);
    @(negedge clk_wiz_o);
    log_q.delete(); done_cnt = 0; done_cyc = -1; last_rdy = -1;
    last_vrun = 0; vtotal = 0; gapv = 0; t0 = cyc;
    mode_i = m; src_addr_i = s; dst_addr_i = d; len_i = n; fill_data_i = f;
    start_i = 1'b1;
    @(negedge clk_wiz_o);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin @(negedge clk_wiz_o); #1; k++; end
    ok = (done_cnt != 0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk_wiz_o);
    #1;
    n_cmp++; if (iomem_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", iomem_valid_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy_o); end
    n_cmp++; if (done_o !== 1'b0 || err_o !== 1'b0) begin n_bad++; $display("FAIL reset_done_err got %b%b want 00", done_o, err_o); end
    n_cmp++; if (iomem_wstrb_o !== 4'h0 || iomem_addr_o !== 32'h0 || iomem_wdata_o !== 32'h0)
      begin n_bad++; $display("FAIL reset_bus got %h/%h/%h want 0/0/0", iomem_wstrb_o, iomem_addr_o, iomem_wdata_o); end
    n_cmp++; if (words_done_o !== 16'h0) begin n_bad++; $display("FAIL reset_words got %0d want 0", words_done_o); end
    @(negedge clk_wiz_o); rst_n = 1'b1;
    repeat (2) @(negedge clk_wiz_o);
  endtask

  task automatic test_fill;
    bit ok;
    lat = 16;
    do_start(1'b1, 32'h0, 32'h4000_0100, 16'd4, 32'hDEAD_BEEF);
    #1;
    n_cmp++; if (busy_o !== 1'b1 || iomem_valid_o !== 1'b1) begin n_bad++; $display("FAIL fill_cycle1 busy/valid got %b%b want 11", busy_o, iomem_valid_o); end
    wait_done(400, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL fill_done timed out want done pulse"); end
    n_cmp++; if (log_q.size() != 4) begin n_bad++; $display("FAIL fill_count got %0d want 4", log_q.size()); end
    for (int i = 0; i < 4 && i < log_q.size(); i++) begin
      n_cmp++;
      if (log_q[i].addr !== 32'h4000_0100 + 32'(4*i) || log_q[i].wstrb !== 4'hF || log_q[i].data !== 32'hDEAD_BEEF)
        begin n_bad++; $display("FAIL fill_wr%0d got %h/%h/%h want %h/f/deadbeef", i, log_q[i].addr, log_q[i].wstrb, log_q[i].data, 32'h4000_0100 + 32'(4*i)); end
    end
    n_cmp++; if (words_done_o !== 16'd4 || err_o !== 1'b0) begin n_bad++; $display("FAIL fill_status words/err got %0d/%b want 4/0", words_done_o, err_o); end
    n_cmp++; if (done_cyc != 73 || busy_o !== 1'b0) begin n_bad++; $display("FAIL fill_timing done_cyc/busy got %0d/%b want 73/0", done_cyc, busy_o); end
  endtask

  task automatic test_copy;
    bit ok;
    lat = 16;
    mem[32'h4000_0000] = 32'd1; mem[32'h4000_0004] = 32'd2; mem[32'h4000_0008] = 32'd3;
    do_start(1'b0, 32'h4000_0000, 32'h4000_0800, 16'd3, 32'h0);
    wait_done(600, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL copy_done timed out want done pulse"); end
    n_cmp++; if (log_q.size() != 6) begin n_bad++; $display("FAIL copy_count got %0d want 6", log_q.size()); end
    for (int k = 0; k < 3 && 2*k+1 < log_q.size(); k++) begin
      n_cmp++;
      if (log_q[2*k].addr !== 32'h4000_0000 + 32'(4*k) || log_q[2*k].wstrb !== 4'h0 ||
          log_q[2*k+1].addr !== 32'h4000_0800 + 32'(4*k) || log_q[2*k+1].wstrb !== 4'hF ||
          log_q[2*k+1].data !== 32'(k+1))
        begin n_bad++; $display("FAIL copy_pair%0d got rd %h/%h wr %h/%h/%h want word %0d", k,
          log_q[2*k].addr, log_q[2*k].wstrb, log_q[2*k+1].addr, log_q[2*k+1].wstrb, log_q[2*k+1].data, k+1); end
    end
    n_cmp++; if (mem[32'h4000_0808] !== 32'd3) begin n_bad++; $display("FAIL copy_dst2 got %h want 3", mem[32'h4000_0808]); end
    n_cmp++; if (gapv != 0) begin n_bad++; $display("FAIL copy_gap got %0d violations want 0", gapv); end
    n_cmp++; if (last_rdy != 107 || done_cyc != 109) begin n_bad++; $display("FAIL copy_timing last_ready/done got %0d/%0d want 107/109", last_rdy, done_cyc); end
  endtask

  task automatic test_zero_len;
    bit ok;
    do_start(1'b1, 32'h0, 32'h4000_0000, 16'd0, 32'h5555_5555);
    wait_done(20, ok);
    n_cmp++; if (!ok || done_cyc != 2) begin n_bad++; $display("FAIL zero_done got ok=%0d cyc=%0d want 1/2", ok, done_cyc); end
    repeat (3) @(negedge clk_wiz_o);
    #1;
    n_cmp++; if (vtotal != 0 || words_done_o !== 16'd0) begin n_bad++; $display("FAIL zero_valid got valid_cycles=%0d words=%0d want 0/0", vtotal, words_done_o); end
  endtask

  task automatic test_timeout;
    bit ok;
    resp_en = 1'b0;
    do_start(1'b1, 32'h0, 32'h4000_0200, 16'd2, 32'h1111_1111);
    wait_done(300, ok);
    n_cmp++; if (!ok || done_cyc != 66) begin n_bad++; $display("FAIL to_done got ok=%0d cyc=%0d want 1/66", ok, done_cyc); end
    n_cmp++; if (err_o !== 1'b1 || words_done_o !== 16'd0) begin n_bad++; $display("FAIL to_status err/words got %b/%0d want 1/0", err_o, words_done_o); end
    n_cmp++; if (last_vrun != 64 || iomem_valid_o !== 1'b0) begin n_bad++; $display("FAIL to_valid_run got %0d/%b want 64/0", last_vrun, iomem_valid_o); end
    resp_en = 1'b1; lat = 1;
    do_start(1'b1, 32'h0, 32'h4000_0300, 16'd1, 32'h2222_2222);
    #1;
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL to_err_clear got %b want 0", err_o); end
    wait_done(50, ok);
    n_cmp++; if (!ok || words_done_o !== 16'd1) begin n_bad++; $display("FAIL to_recover got ok=%0d words=%0d want 1/1", ok, words_done_o); end
  endtask

  task automatic test_wrap_ignored_start;
    bit ok;
    lat = 2;
    do_start(1'b1, 32'h0, 32'hFFFF_FFFC, 16'd2, 32'h1234_5678);
    @(negedge clk_wiz_o);
    mode_i = 1'b0; src_addr_i = 32'h100; dst_addr_i = 32'h200; len_i = 16'd5; fill_data_i = 32'hAAAA_AAAA;
    start_i = 1'b1;
    @(negedge clk_wiz_o);
    start_i = 1'b0;
    wait_done(50, ok);
    n_cmp++; if (!ok || done_cyc != 9) begin n_bad++; $display("FAIL wrap_done got ok=%0d cyc=%0d want 1/9", ok, done_cyc); end
    n_cmp++; if (log_q.size() != 2) begin n_bad++; $display("FAIL wrap_count got %0d want 2", log_q.size()); end
    else begin
      n_cmp++; if (log_q[0].addr !== 32'hFFFF_FFFC || log_q[1].addr !== 32'h0)
        begin n_bad++; $display("FAIL wrap_addr got %h,%h want fffffffc,00000000", log_q[0].addr, log_q[1].addr); end
      n_cmp++; if (log_q[1].data !== 32'h1234_5678 || log_q[1].wstrb !== 4'hF)
        begin n_bad++; $display("FAIL wrap_data got %h/%h want 12345678/f", log_q[1].data, log_q[1].wstrb); end
    end
    repeat (10) @(negedge clk_wiz_o);
    #1;
    n_cmp++; if (done_cnt != 1 || busy_o !== 1'b0 || words_done_o !== 16'd2)
      begin n_bad++; $display("FAIL wrap_ignored got dones=%0d busy=%b words=%0d want 1/0/2", done_cnt, busy_o, words_done_o); end
  endtask

  task automatic test_reset_mid_op;
    bit ok, hit;
    int k;
    lat = 4;
    do_start(1'b0, 32'h4000_0000, 32'h4000_0900, 16'd3, 32'h0);
    hit = 1'b0; k = 0;
    while (!hit && k < 200) begin
      @(negedge clk_wiz_o); #1; k++;
      hit = (words_done_o == 16'd1) && iomem_valid_o && (iomem_wstrb_o == 4'hF);
    end
    n_cmp++; if (!hit) begin n_bad++; $display("FAIL rstmid_reach_wr timed out want second write"); end
    rst_n = 1'b0;
    @(posedge clk_wiz_o); #1;
    n_cmp++; if (iomem_valid_o !== 1'b0 || busy_o !== 1'b0 || iomem_wstrb_o !== 4'h0 || words_done_o !== 16'd0)
      begin n_bad++; $display("FAIL rstmid_outputs got valid=%b busy=%b wstrb=%h words=%0d want 0/0/0/0",
        iomem_valid_o, busy_o, iomem_wstrb_o, words_done_o); end
    @(negedge clk_wiz_o); rst_n = 1'b1;
    do_start(1'b1, 32'h0, 32'h4000_0A00, 16'd2, 32'h0BAD_F00D);
    wait_done(100, ok);
    n_cmp++; if (!ok || words_done_o !== 16'd2 || err_o !== 1'b0)
      begin n_bad++; $display("FAIL rstmid_restart got ok=%0d words=%0d err=%b want 1/2/0", ok, words_done_o, err_o); end
    n_cmp++; if (mem[32'h4000_0A04] !== 32'h0BAD_F00D) begin n_bad++; $display("FAIL rstmid_data got %h want 0badf00d", mem[32'h4000_0A04]); end
  endtask

  initial begin
    test_reset;
    test_fill;
    test_copy;
    test_zero_len;
    test_timeout;
    test_wrap_ignored_start;
    test_reset_mid_op;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout sim time exceeded want completion");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/iomem_copy_master.md
# iomem_copy_master

Bus-initiator engine that drives the picorv32-style `iomem` handshake from the master side, performing word block-copy and block-fill transactions against any `iomem` responder: the main-memory path with its fixed ready delay, the timer registers, or a bench model. It lets the board-level wrapper initialise or scrub main memory, and run memory self-tests, without the soft core. It also serves as the reusable initiator model for responder verification. Its bus outputs are muxed with the core's `iomem` outputs at the wrapper level.

## Interface
Parameters:
- `LEN_W`, 16: width of the word-count input and of the progress counter.
- `TIMEOUT_CYCLES`, 64: maximum number of cycles `iomem_valid_o` may stay high without `iomem_ready_i` before the operation aborts. Must be greater than 1.

Ports:
- `clk_wiz_o`, in, 1: clock.
- `rst_n`, in, 1: reset, synchronous, active-low. The clock is `clk_wiz_o`.
- `start_i`, in, 1: single-cycle request. Sampled only in IDLE.
- `mode_i`, in, 1: operation select, 0 = copy, 1 = fill. Captured on start.
- `src_addr_i`, in, 32: copy source byte address. Bits [1:0] are forced to 0.
- `dst_addr_i`, in, 32: destination byte address. Bits [1:0] are forced to 0.
- `len_i`, in, LEN_W: number of 32-bit words to transfer.
- `fill_data_i`, in, 32: pattern written in fill mode. Captured on start.
- `busy_o`, out, 1: high from the cycle after an accepted start until the done pulse.
- `done_o`, out, 1: one-cycle completion pulse. Fires on success and on abort.
- `err_o`, out, 1: timeout flag. Sticky; cleared by the next accepted start.
- `words_done_o`, out, LEN_W: count of completed destination writes.
- `iomem_valid_o`, out, 1: transaction request.
- `iomem_ready_i`, in, 1: responder completion.
- `iomem_wstrb_o`, out, 4: write strobes. 4'h0 means a read.
- `iomem_addr_o`, out, 32: transaction address.
- `iomem_wdata_o`, out, 32: write data.
- `iomem_rdata_i`, in, 32: read data. Valid only in the cycle where `iomem_ready_i` is high.

## Operation
States are IDLE, RD, GAP_R, WR, GAP_W and FIN.

- **IDLE.** On `start_i`, capture mode, both addresses (bits [1:0] cleared), `len_i` and the fill pattern. Clear `err_o` and `words_done_o`.
  - If `len_i` is 0, go to FIN.
  - Otherwise go to RD for copy, or WR for fill.
- **RD.** Drive valid=1, wstrb=0, addr=src. On valid & ready, latch `iomem_rdata_i` into the data register, advance src by 4, and go to GAP_R.
- **GAP_R.** Drive valid=0 for exactly one cycle, then go to WR.
- **WR.** Drive valid=1, wstrb=4'hF, addr=dst. Wdata is the data register for copy, or the fill pattern for fill. On valid & ready:
  - advance dst by 4;
  - increment `words_done_o`;
  - if the incremented count equals the length, go to FIN; otherwise go to GAP_W.
- **GAP_W.** Drive valid=0 for one cycle, then go to RD for copy or WR for fill.
- **FIN.** Pulse `done_o` for one cycle and return to IDLE.

Bus rules:
- Address arithmetic is modulo 2^32. Incrementing from 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Addr, wstrb and wdata are held stable while valid is high.
- Valid never drops without a ready, except on timeout or reset.

Timeout:
- A watchdog counter is cleared whenever valid is low or ready is high, and increments otherwise.
- When it reaches `TIMEOUT_CYCLES`, the engine drops valid the next cycle, sets `err_o`, and goes to FIN.
- `words_done_o` keeps the count of writes already completed.

Other boundary conditions:
- `start_i` while busy is ignored and has no effect on captured values.
- Ready while valid is low is ignored.
- Reset mid-operation: in the first cycle with `rst_n` low, all outputs return to reset values.

Reset values: state=IDLE; `busy_o`, `done_o`, `err_o` and `iomem_valid_o` = 0; `iomem_wstrb_o`=0; `iomem_addr_o`=0; `iomem_wdata_o`=0; `words_done_o`=0.

## Timing
- Start accepted at cycle 0. Valid and `busy_o` rise at cycle 1.
- A responder with ready at cycle 1+L completes the first transaction.
- Per word, with a responder of fixed latency L (ready L cycles after valid rises):
  - copy costs 2·(L+2) cycles;
  - fill costs L+2 cycles;
  - the final write omits its gap cycle.
- `done_o` is asserted the cycle after FIN is entered, i.e. 2 cycles after the final ready.
- `busy_o` falls in the same cycle as the done pulse.
- `err_o` is visible no later than the done pulse of the aborted operation.
- No combinational path exists from `iomem_ready_i` or `iomem_rdata_i` to any output. All outputs are registered.

## Structure
- Shared package `iomem_pkg`:
  - the state encoding;
  - localparams `WSTRB_READ=4'h0` and `WSTRB_WORD=4'hF`;
  - the memory-map constants for main-memory base and mask, plus the timer low/high addresses (32'h3000_0000 and 32'h3000_0004).
- One natural sub-module, `iomem_watchdog`: the timeout counter, with inputs valid and ready and a single-cycle `expired` output.
- The datapath (address counters, data register, length compare) stays in the top module.

## Test plan
1. **Fill.** Fill dst=32'h4000_0100, len=4, pattern=32'hDEAD_BEEF against a latency-16 responder.
   - Required: four writes to 0x100, 0x104, 0x108 and 0x10C, each with wstrb=F.
   - Required: `done_o` pulses, `words_done_o`=4, `err_o`=0.
2. **Copy.** Copy src=32'h4000_0000 to dst=32'h4000_0800, len=3, source preloaded with 1, 2, 3.
   - Required: bus alternates read/write, with a one-cycle valid gap after every ready.
   - Required: destination holds 1, 2, 3, with total latency 3·2·18−1 cycles.
3. **Zero length.** `len_i`=0.
   - Required: no valid is ever asserted, and `done_o` pulses at cycle 2 after start.
4. **Timeout.** Responder never asserts ready, TIMEOUT_CYCLES=64, fill len=2.
   - Required: valid is high for exactly 64 cycles, then low.
   - Required: `err_o`=1, `done_o` pulses, `words_done_o`=0.
   - Required: a following start clears `err_o`.
5. **Wrap and ignored start.** Fill dst=32'hFFFF_FFFC, len=2; pulse `start_i` mid-transfer with different parameters.
   - Required: writes go to FFFF_FFFC then 0000_0000.
   - Required: the second start is ignored.
6. **Reset mid-operation.** Assert `rst_n` low during a copy while in WR.
   - Required: valid, busy, wstrb and `words_done_o` are all 0 in the first reset cycle.
   - Required: a new start after reset completes normally.
